// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester block.
// Holds the per-channel FSM state encoding, the default channel count
// and the beat-counter width (wide enough for bursts of up to 15 cycles).
package arb_pkg;

  localparam int CHANNELS_DEF = 8;
  localparam int BEAT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_XFER = 2'b10
  } chan_state_t;

endpackage

// File: rtl/arb_requester_if.sv
// Handshake bundle between job sources, the requester block and the arbiter.
//   job_valid : one-cycle job pulses per channel (into the requester)
//   grant     : registered one-hot grant from the arbiter (into the requester)
//   request   : registered request lines to the arbiter
//   xfer      : high while a channel is in its transfer window
//   done      : one-cycle pulse on the last transfer cycle of a job
//   overflow  : sticky per-channel dropped-job flag
//   proto_err : sticky flags, bit0 spurious grant, bit1 multi-hot grant
// The master modport is the environment side; slave is the requester side.
interface arb_requester_if import arb_pkg::*; #(
  parameter int CHANNELS = CHANNELS_DEF
);

  logic [CHANNELS-1:0] job_valid;
  logic [CHANNELS-1:0] grant;
  logic [CHANNELS-1:0] request;
  logic [CHANNELS-1:0] xfer;
  logic [CHANNELS-1:0] done;
  logic [CHANNELS-1:0] overflow;
  logic [1:0]          proto_err;

  modport master (
    output job_valid, grant,
    input  request, xfer, done, overflow, proto_err
  );

  modport slave (
    input  job_valid, grant,
    output request, xfer, done, overflow, proto_err
  );

endinterface

// File: rtl/arb_req_chan.sv
// One requester channel: pending-job counter, IDLE/REQ/XFER FSM and beat
// counter, all in a single clocked block so every output is registered.
//   clk, reset : system clock, synchronous active-low reset
//   job_valid  : enqueue one job this cycle
//   grant      : arbiter grant for this channel (only honoured in REQ)
//   request    : high while in REQ
//   xfer       : high for the BURST_LEN cycles of a transfer
//   done       : high on the last transfer cycle
//   overflow   : sticky, set when a job arrives at a saturated counter
module arb_req_chan import arb_pkg::*; #(
  parameter int BURST_LEN = 4,
  parameter int PEND_W    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic job_valid,
  input  logic grant,
  output logic request,
  output logic xfer,
  output logic done,
  output logic overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  chan_state_t       state_r;
  logic [PEND_W-1:0] pend_r;
  logic [BEAT_W-1:0] beat_r;
  logic              request_r;
  logic              xfer_r;
  logic              done_r;
  logic              overflow_r;
  logic              accept_s;

  // A grant only counts as accepted while the channel is actually requesting.
  assign accept_s = (state_r == ST_REQ) && grant;

  // Pending counter, FSM, beat counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      pend_r     <= {PEND_W{1'b0}};
      beat_r     <= {BEAT_W{1'b0}};
      request_r  <= 1'b0;
      xfer_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      // Simultaneous enqueue and accept cancel out, so no drop is possible.
      if (job_valid && accept_s) begin
        pend_r <= pend_r;
      end else if (accept_s) begin
        pend_r <= pend_r - PEND_ONE;
      end else if (job_valid) begin
        if (pend_r == PEND_MAX) begin
          overflow_r <= 1'b1;
        end else begin
          pend_r <= pend_r + PEND_ONE;
        end
      end else begin
        pend_r <= pend_r;
      end

      request_r <= 1'b0;
      xfer_r    <= 1'b0;
      done_r    <= 1'b0;

      // State decisions use the pending count registered before this edge.
      case (state_r)
        ST_IDLE: begin
          if (pend_r != {PEND_W{1'b0}}) begin
            state_r   <= ST_REQ;
            request_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (grant) begin
            state_r <= ST_XFER;
            beat_r  <= {BEAT_W{1'b0}};
            xfer_r  <= 1'b1;
            done_r  <= (BEAT_LAST == {BEAT_W{1'b0}});
          end else begin
            state_r   <= ST_REQ;
            request_r <= 1'b1;
          end
        end
        ST_XFER: begin
          if (beat_r == BEAT_LAST) begin
            beat_r <= {BEAT_W{1'b0}};
            if (pend_r != {PEND_W{1'b0}}) begin
              state_r   <= ST_REQ;
              request_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_XFER;
            beat_r  <= beat_r + BEAT_ONE;
            xfer_r  <= 1'b1;
            done_r  <= ((beat_r + BEAT_ONE) == BEAT_LAST);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          beat_r  <= {BEAT_W{1'b0}};
        end
      endcase
    end
  end

  assign request  = request_r;
  assign xfer     = xfer_r;
  assign done     = done_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/arb_requester.sv
// Multi-channel arbiter requester: CHANNELS independent arb_req_chan
// instances plus an optional grant protocol checker.
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : arb_requester_if.slave (job_valid, grant in; request, xfer,
//           done, overflow, proto_err out)
// Optional feature: define ARB_REQ_PROTO_CHECK_EN to build the sticky
// spurious-grant / multi-hot-grant checker; otherwise proto_err is 0.
module arb_requester import arb_pkg::*; #(
  parameter int CHANNELS  = CHANNELS_DEF,
  parameter int BURST_LEN = 4,
  parameter int PEND_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  arb_requester_if.slave     bus
);

  logic [CHANNELS-1:0] request_s;
  logic [CHANNELS-1:0] xfer_s;
  logic [CHANNELS-1:0] done_s;
  logic [CHANNELS-1:0] overflow_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    arb_req_chan #(
      .BURST_LEN (BURST_LEN),
      .PEND_W    (PEND_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .job_valid (bus.job_valid[i]),
      .grant     (bus.grant[i]),
      .request   (request_s[i]),
      .xfer      (xfer_s[i]),
      .done      (done_s[i]),
      .overflow  (overflow_s[i])
    );
  end

  assign bus.request  = request_s;
  assign bus.xfer     = xfer_s;
  assign bus.done     = done_s;
  assign bus.overflow = overflow_s;

`ifdef ARB_REQ_PROTO_CHECK_EN
  logic [1:0] proto_err_r;
  logic       spurious_s;
  logic       multi_s;

  // True when more than one bit of v is set (clearing the lowest set bit leaves something).
  function automatic logic multi_hot(input logic [CHANNELS-1:0] v);
    return (v & (v - CHANNELS'(1))) != {CHANNELS{1'b0}};
  endfunction

  // Compared against the registered request, i.e. what the arbiter saw.
  assign spurious_s = |(bus.grant & ~request_s);
  assign multi_s    = multi_hot(bus.grant);

  // Sticky protocol error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      proto_err_r <= 2'b00;
    end else begin
      proto_err_r <= proto_err_r | {multi_s, spurious_s};
    end
  end

  assign bus.proto_err = proto_err_r;
`else
  assign bus.proto_err = 2'b00;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed, scoreboard-based bench for arb_requester (8 channels,
// BURST_LEN 4, PEND_W 3). Each step pushes the expected registered outputs,
// applies inputs for one clock and pops/compares at the falling edge.
module tb_arb_requester;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

`ifdef ARB_REQ_PROTO_CHECK_EN
  localparam logic [1:0] PERR_MASK = 2'b11;
`else
  localparam logic [1:0] PERR_MASK = 2'b00;
`endif

  typedef struct {
    string      tag;
    logic [7:0] req;
    logic [7:0] xfr;
    logic [7:0] dne;
    logic [7:0] ovf;
    logic [1:0] perr;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] exp_perr = 2'b00;

  arb_requester_if #(.CHANNELS(8)) bus ();

  arb_requester #(
    .CHANNELS  (8),
    .BURST_LEN (4),
    .PEND_W    (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input string tag, input logic [7:0] jv, input logic [7:0] gr,
                      input logic [7:0] e_req, input logic [7:0] e_xfr,
                      input logic [7:0] e_dne, input logic [7:0] e_ovf);
    exp_t e;
    e.tag = tag; e.req = e_req; e.xfr = e_xfr; e.dne = e_dne; e.ovf = e_ovf;
    e.perr = exp_perr;
    sb.push_back(e);
    bus.job_valid = jv;
    bus.grant     = gr;
    @(posedge clk);
    @(negedge clk);
    bus.job_valid = 8'h00;
    bus.grant     = 8'h00;
    e = sb.pop_front();
    chk({e.tag, ".request"},  bus.request,  e.req);
    chk({e.tag, ".xfer"},     bus.xfer,     e.xfr);
    chk({e.tag, ".done"},     bus.done,     e.dne);
    chk({e.tag, ".overflow"}, bus.overflow, e.ovf);
    chk({e.tag, ".proto_err"}, {6'b000000, bus.proto_err}, {6'b000000, e.perr});
  endtask

  initial begin
    bus.job_valid = 8'h00;
    bus.grant     = 8'h00;
    @(negedge clk);

    // Reset state.
    reset = 1'b0;
    step("rst0", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("rst1", 8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;

    // Single job on ch2: 2-cycle latency, grant, 4-beat burst, done on beat 3.
    step("c2_jv",   8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("c2_req",  8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
    step("c2_b0",   8'h00, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00);
    step("c2_b1",   8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00);
    step("c2_b2",   8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00);
    step("c2_b3",   8'h00, 8'h00, 8'h00, 8'h04, 8'h04, 8'h00);
    step("c2_idle", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Three jobs on ch0, third pulse coincides with the first grant.
    step("c0_jv0", 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("c0_jv1", 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
    for (int j = 0; j < 3; j++) begin
      step("c0_b0", (j == 0) ? 8'h01 : 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00);
      step("c0_b1", 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
      step("c0_b2", 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
      step("c0_b3", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00);
      step("c0_nxt", 8'h00, 8'h00, (j < 2) ? 8'h01 : 8'h00, 8'h00, 8'h00, 8'h00);
    end
    step("c0_drained", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // ch5: fill to 7, enqueue+accept at saturation, then a dropped job.
    for (int k = 0; k < 7; k++)
      step("c5_fill", 8'h20, 8'h00, (k == 0) ? 8'h00 : 8'h20, 8'h00, 8'h00, 8'h00);
    step("c5_sat_acc",  8'h20, 8'h20, 8'h00, 8'h20, 8'h00, 8'h00);
    step("c5_sat_drop", 8'h20, 8'h00, 8'h00, 8'h20, 8'h00, 8'h20);
    step("c5_b2",       8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h20);
    step("c5_b3",       8'h00, 8'h00, 8'h00, 8'h20, 8'h20, 8'h20);
    step("c5_req",      8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h20);
    // Exactly seven queued jobs remain; a grant mid-burst is ignored.
    for (int b = 0; b < 7; b++) begin
      step("c5_d0", 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h20);
      exp_perr = exp_perr | (2'b01 & PERR_MASK);
      step("c5_d1", 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h20);
      step("c5_d2", 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h20);
      step("c5_d3", 8'h00, 8'h00, 8'h00, 8'h20, 8'h20, 8'h20);
      step("c5_dn", 8'h00, 8'h00, (b < 6) ? 8'h20 : 8'h00, 8'h00, 8'h00, 8'h20);
    end
    step("c5_empty", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20);

    // Reset clears sticky flags.
    reset = 1'b0;
    exp_perr = 2'b00;
    step("rst_sticky", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;

    // Multi-hot grant to two requesting channels.
    step("mh_jv",  8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("mh_req", 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00);
    exp_perr = exp_perr | (2'b10 & PERR_MASK);
    step("mh_b0",  8'h00, 8'h81, 8'h00, 8'h81, 8'h00, 8'h00);
    step("mh_b1",  8'h00, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00);
    step("mh_b2",  8'h00, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00);
    step("mh_b3",  8'h00, 8'h00, 8'h00, 8'h81, 8'h81, 8'h00);
    step("mh_end", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    exp_perr = 2'b00;
    step("rst_perr", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;

    // Spurious grant to idle ch1, then stays sticky.
    exp_perr = exp_perr | (2'b01 & PERR_MASK);
    step("sp_gnt",  8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
    step("sp_hold", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset during beat 2 of a ch1 burst with one more job pending.
    step("ra_jv",  8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("ra_req", 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00);
    step("ra_b0",  8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h00);
    step("ra_b1",  8'h02, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00);
    step("ra_b2",  8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00);
    reset = 1'b0;
    exp_perr = 2'b00;
    step("ra_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    step("ra_rel0", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("ra_rel1", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("ra_rel2", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter CHANNELS, default 8, SHALL set the number of requestor channels.
REQ-002 Parameter BURST_LEN, default 4, SHALL set the transfer cycles per granted job (range 1..15).
REQ-003 Parameter PEND_W, default 3, SHALL set the per-channel pending-job counter width.
REQ-004 clk  input  1  SHALL be the single system clock; all logic on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-006 job_valid  input  CHANNELS  SHALL carry one-cycle pulses that each enqueue one job on that channel.
REQ-007 grant  input  CHANNELS  SHALL be the arbiter's registered one-hot grant vector.
REQ-008 request  output  CHANNELS  SHALL be the registered per-channel request lines to the arbiter.
REQ-009 xfer  output  CHANNELS  SHALL be high while that channel is in its transfer window.
REQ-010 done  output  CHANNELS  SHALL pulse one cycle on the last transfer cycle of a job.
REQ-011 overflow  output  CHANNELS  SHALL be a sticky flag for dropped jobs.
REQ-012 proto_err  output  2  SHALL be sticky flags: bit0 spurious grant, bit1 multi-hot grant.

Function
REQ-013 Each channel SHALL run an independent FSM with states IDLE, REQ and XFER.
REQ-014 IDLE SHALL go to REQ on the cycle after the pending count becomes nonzero.
REQ-015 In REQ, request[i] SHALL be 1, and it SHALL be 0 in IDLE and XFER.
REQ-016 REQ SHALL go to XFER on any cycle where grant[i]=1; the pending count decrements by 1 on the same edge.
REQ-017 XFER SHALL last exactly BURST_LEN cycles, with xfer[i]=1 throughout and a beat counter running 0..BURST_LEN-1.
REQ-018 done[i] SHALL be 1 in the cycle where the beat count equals BURST_LEN-1.
REQ-019 After the last XFER cycle, the FSM SHALL go to REQ if pending is nonzero, else to IDLE; there are no idle gap cycles.
REQ-020 grant[i] while in IDLE or XFER SHALL be ignored by the FSM.
REQ-021 The pending counter SHALL increment on job_valid[i] and saturate at 2^PEND_W-1.
REQ-022 A job_valid[i] arriving at saturation SHALL be dropped and set overflow[i].
REQ-023 job_valid[i] and a grant acceptance in the same cycle SHALL leave the count unchanged, and SHALL NOT set overflow even when the counter is saturated.
REQ-024 The pending count SHALL be taken from the value registered before the edge; job_valid latency to request SHALL be 2 cycles from IDLE.

Reset
REQ-025 While reset=0 at a clk edge, all FSMs SHALL enter IDLE.
REQ-026 While reset=0 at a clk edge, all counters SHALL clear to 0.
REQ-027 While reset=0 at a clk edge, request, xfer, done, overflow and proto_err SHALL all be 0.
REQ-028 A reset asserted mid-XFER SHALL abort the job without a done pulse; pending jobs are discarded.

Configuration
REQ-029 Macro ARB_REQ_PROTO_CHECK_EN defined: proto_err[0] SHALL set on grant[i]=1 while request[i]=0, and proto_err[1] SHALL set on more than one grant bit high.
REQ-030 Macro ARB_REQ_PROTO_CHECK_EN undefined: proto_err SHALL be tied to 0 and no checker logic is synthesized; FSM behaviour is identical in both cases.

Structure
REQ-031 The shared package arb_pkg SHALL hold the FSM state typedef (IDLE/REQ/XFER encoding) and the default CHANNELS constant.
REQ-032 The per-channel FSM, pending counter and beat counter SHALL be the sub-module arb_req_chan, instantiated CHANNELS times in a generate loop.
REQ-033 The protocol checker SHALL live in the top level, outside arb_req_chan.

Verification
REQ-034 Job pulse on ch2, grant=8'h04 one cycle after request[2] rises -> request[2] falls, xfer[2] high 4 cycles, done[2] on the 4th.
REQ-035 Three pulses on ch0, each granted -> three back-to-back bursts, request[0] re-rises immediately after each done, pending ends at 0.
REQ-036 Eight pulses on ch5 with PEND_W=3, no grant -> pending=7 and overflow[5]=1 after the 8th pulse.
REQ-037 Pending saturated at 7 on ch5, job_valid[5] and grant[5] in the same cycle -> pending stays 7 and overflow[5] is unchanged.
REQ-038 With the macro defined, grant=8'h81 or grant to a non-requesting channel -> proto_err=2'b10 or 2'b01 respectively, and sticky.
REQ-039 reset=0 during beat 2 of XFER on ch1 -> all outputs 0 next cycle, no done[1], IDLE after release.
